// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the retire trace path.
//   XLEN           : architectural register width of the core
//   TRACE_SEQ_W    : width of the retire sequence number
//   retire_entry_t : one captured retirement as stored in the trace FIFO
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN        = 32;
   localparam int TRACE_SEQ_W = 32;

   typedef struct packed {
      logic [TRACE_SEQ_W-1:0] seq;
      logic [XLEN-1:0]        pc;
      logic [XLEN-1:0]        instr;
      logic [4:0]             reg_addr;
      logic [XLEN-1:0]        reg_data;
      logic [XLEN-1:0]        mem_addr;
      logic [XLEN-1:0]        mem_data;
      logic                   mem_wrt;
   } retire_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// First-word-fall-through synchronous FIFO. The head entry is presented on
// rdata_o whenever empty_o is low; pop_i consumes it.
//   clk_i / rstn_i : clock, asynchronous active-low reset (pointers, level)
//   clr_i          : synchronous flush, wins over push and pop
//   push_i, wdata_i: write request and data (ignored when full without pop)
//   pop_i          : read request (ignored when empty)
//   rdata_o        : head entry
//   full_o/empty_o : status flags
//   level_o        : registered number of stored entries
// Storage is not reset; only the pointers define valid contents.
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [LW-1:0]    r_wptr;
   logic [LW-1:0]    r_rptr;
   logic [LW-1:0]    r_level;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_empty = (r_wptr == r_rptr);
   assign w_pop   = pop_i & ~w_empty & ~clr_i;
   // A pop in the same cycle frees the slot, so full does not block the push.
   assign w_push  = push_i & (~w_full | w_pop) & ~clr_i;

   // Read and write pointer update.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wptr <= {LW{1'b0}};
         r_rptr <= {LW{1'b0}};
      end else if (clr_i) begin
         r_wptr <= {LW{1'b0}};
         r_rptr <= {LW{1'b0}};
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + LW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + LW'(1);
         end
      end
   end

   // Registered fill level, updated on the same edge as the pointers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_level <= {LW{1'b0}};
      end else if (clr_i) begin
         r_level <= {LW{1'b0}};
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage write; contents outside the pointer window are don't-care.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[r_rptr[AW-1:0]];
   assign full_o  = w_full;
   assign empty_o = w_empty;
   assign level_o = r_level;

endmodule

// File: rtl/retire_trace_buffer.sv
// ---------------------------------------------------------------------------
// retire_trace_buffer
// Captures every retirement of the core into a FWFT FIFO, stamps it with a
// 32-bit retire sequence number and drains it over valid/ready. The core is
// never stalled: retirements arriving while full are dropped and counted.
//   clk_i, rstn_i    : clock, asynchronous active-low reset
//   clear_i          : synchronous flush of FIFO, sequence and drop state
//   enable_i         : capture enable
//   update_i + pc_i/instr_i/reg_*_i/mem_*_i : retire port of the core
//   trace_valid_o/trace_ready_i : head handshake
//   trace_*_o        : head entry fields, zero when empty
//   level_o          : stored entries
//   drop_cnt_o       : saturating count of dropped retirements
//   overflow_o       : sticky, set on the first drop
// ---------------------------------------------------------------------------
module retire_trace_buffer
   import riscv_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int DROP_W = 16,
   localparam int LW     = $clog2(DEPTH) + 1
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   clear_i,
   input  logic                   enable_i,
   input  logic                   update_i,
   input  logic [XLEN-1:0]        pc_i,
   input  logic [XLEN-1:0]        instr_i,
   input  logic [4:0]             reg_addr_i,
   input  logic [XLEN-1:0]        reg_data_i,
   input  logic [XLEN-1:0]        mem_addr_i,
   input  logic [XLEN-1:0]        mem_data_i,
   input  logic                   mem_wrt_i,
   output logic                   trace_valid_o,
   input  logic                   trace_ready_i,
   output logic [TRACE_SEQ_W-1:0] trace_seq_o,
   output logic [XLEN-1:0]        trace_pc_o,
   output logic [XLEN-1:0]        trace_instr_o,
   output logic [4:0]             trace_reg_addr_o,
   output logic [XLEN-1:0]        trace_reg_data_o,
   output logic [XLEN-1:0]        trace_mem_addr_o,
   output logic [XLEN-1:0]        trace_mem_data_o,
   output logic                   trace_mem_wrt_o,
   output logic [LW-1:0]          level_o,
   output logic [DROP_W-1:0]      drop_cnt_o,
   output logic                   overflow_o
);

   localparam int ENTRY_W = $bits(retire_entry_t);

   logic [TRACE_SEQ_W-1:0] r_seq;
   logic [DROP_W-1:0]      r_drop_cnt;
   logic                   r_overflow;

   logic                   w_capture;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_drop;
   logic                   w_full;
   logic                   w_empty;
   retire_entry_t          w_wentry;
   retire_entry_t          w_rentry;
   retire_entry_t          w_head;
   logic [ENTRY_W-1:0]     w_rdata;

   assign w_capture = enable_i & update_i;
   assign w_pop     = ~w_empty & trace_ready_i;
   assign w_push    = w_capture & (~w_full | w_pop) & ~clear_i;
   assign w_drop    = w_capture & w_full & ~w_pop & ~clear_i;

   // The entry carries the pre-increment sequence number.
   assign w_wentry.seq      = r_seq;
   assign w_wentry.pc       = pc_i;
   assign w_wentry.instr    = instr_i;
   assign w_wentry.reg_addr = reg_addr_i;
   assign w_wentry.reg_data = reg_data_i;
   assign w_wentry.mem_addr = mem_addr_i;
   assign w_wentry.mem_data = mem_data_i;
   assign w_wentry.mem_wrt  = mem_wrt_i;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .clr_i   (clear_i),
      .push_i  (w_push),
      .wdata_i (w_wentry),
      .pop_i   (w_pop),
      .rdata_o (w_rdata),
      .full_o  (w_full),
      .empty_o (w_empty),
      .level_o (level_o)
   );

   assign w_rentry = retire_entry_t'(w_rdata);

   // Sequence counter advances on every capture, pushed or dropped.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_seq <= {TRACE_SEQ_W{1'b0}};
      end else if (clear_i) begin
         r_seq <= {TRACE_SEQ_W{1'b0}};
      end else if (w_capture) begin
         r_seq <= r_seq + TRACE_SEQ_W'(1);
      end
   end

   // Saturating drop counter and sticky overflow flag.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_drop_cnt <= {DROP_W{1'b0}};
         r_overflow <= 1'b0;
      end else if (clear_i) begin
         r_drop_cnt <= {DROP_W{1'b0}};
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != {DROP_W{1'b1}}) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
         end
      end
   end

   // Head fields are masked to zero while the FIFO is empty so stale
   // storage never leaks onto the trace port.
   always_comb begin
      w_head = '0;
      if (!w_empty) begin
         w_head = w_rentry;
      end else begin
         w_head = '0;
      end
   end

   assign trace_valid_o    = ~w_empty;
   assign trace_seq_o      = w_head.seq;
   assign trace_pc_o       = w_head.pc;
   assign trace_instr_o    = w_head.instr;
   assign trace_reg_addr_o = w_head.reg_addr;
   assign trace_reg_data_o = w_head.reg_data;
   assign trace_mem_addr_o = w_head.mem_addr;
   assign trace_mem_data_o = w_head.mem_data;
   assign trace_mem_wrt_o  = w_head.mem_wrt;
   assign drop_cnt_o       = r_drop_cnt;
   assign overflow_o       = r_overflow;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_retire_trace_buffer
// Directed, table-driven bench for retire_trace_buffer (DEPTH 16, narrow
// drop counter so saturation is reachable), plus hand-written sequences for
// overflow, full push+pop, ready toggling and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_retire_trace_buffer;

   localparam int DEPTH  = 16;
   localparam int DROP_W = 3;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic              clk_i = 1'b0;
   logic              rstn_i;
   logic              clear_i;
   logic              enable_i;
   logic              update_i;
   logic [31:0]       pc_i;
   logic [31:0]       instr_i;
   logic [4:0]        reg_addr_i;
   logic [31:0]       reg_data_i;
   logic [31:0]       mem_addr_i;
   logic [31:0]       mem_data_i;
   logic              mem_wrt_i;
   logic              trace_valid_o;
   logic              trace_ready_i;
   logic [31:0]       trace_seq_o;
   logic [31:0]       trace_pc_o;
   logic [31:0]       trace_instr_o;
   logic [4:0]        trace_reg_addr_o;
   logic [31:0]       trace_reg_data_o;
   logic [31:0]       trace_mem_addr_o;
   logic [31:0]       trace_mem_data_o;
   logic              trace_mem_wrt_o;
   logic [LW-1:0]     level_o;
   logic [DROP_W-1:0] drop_cnt_o;
   logic              overflow_o;

   int n_tests = 0;
   int n_fail  = 0;

   retire_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .clear_i          (clear_i),
      .enable_i         (enable_i),
      .update_i         (update_i),
      .pc_i             (pc_i),
      .instr_i          (instr_i),
      .reg_addr_i       (reg_addr_i),
      .reg_data_i       (reg_data_i),
      .mem_addr_i       (mem_addr_i),
      .mem_data_i       (mem_data_i),
      .mem_wrt_i        (mem_wrt_i),
      .trace_valid_o    (trace_valid_o),
      .trace_ready_i    (trace_ready_i),
      .trace_seq_o      (trace_seq_o),
      .trace_pc_o       (trace_pc_o),
      .trace_instr_o    (trace_instr_o),
      .trace_reg_addr_o (trace_reg_addr_o),
      .trace_reg_data_o (trace_reg_data_o),
      .trace_mem_addr_o (trace_mem_addr_o),
      .trace_mem_data_o (trace_mem_data_o),
      .trace_mem_wrt_o  (trace_mem_wrt_o),
      .level_o          (level_o),
      .drop_cnt_o       (drop_cnt_o),
      .overflow_o       (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          clr;
      bit          en;
      bit          upd;
      bit          rdy;
      logic [31:0] pc;
      bit          ev;
      logic [31:0] eseq;
      logic [31:0] epc;
      int          elvl;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] instr_of(logic [31:0] pc);
      return pc ^ 32'h0050_0093;
   endfunction

   function automatic void add(bit clr, bit en, bit upd, bit rdy, logic [31:0] pc,
                               bit ev, logic [31:0] eseq, logic [31:0] epc, int elvl);
      vec_t v;
      v.clr = clr; v.en = en; v.upd = upd; v.rdy = rdy; v.pc = pc;
      v.ev = ev; v.eseq = eseq; v.epc = epc; v.elvl = elvl;
      vecs.push_back(v);
   endfunction

   // Expected head image; side fields follow the stimulus derivation in step().
   function automatic logic [255:0] exp_head(bit v, logic [31:0] seq, logic [31:0] pc,
                                             logic [31:0] instr);
      if (!v) return 256'd0;
      return {57'd0, 1'b1, seq, pc, instr, pc[6:2], ~pc, pc + 32'h0000_1000,
              {pc[15:0], pc[31:16]}, pc[2]};
   endfunction

   function automatic logic [255:0] act_head();
      return {57'd0, trace_valid_o, trace_seq_o, trace_pc_o, trace_instr_o, trace_reg_addr_o,
              trace_reg_data_o, trace_mem_addr_o, trace_mem_data_o, trace_mem_wrt_o};
   endfunction

   task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_head(string name, bit v, logic [31:0] seq, logic [31:0] pc,
                           logic [31:0] instr);
      chk(name, act_head(), exp_head(v, seq, pc, instr));
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(bit clr, bit en, bit upd, bit rdy, logic [31:0] pc, logic [31:0] instr);
      clear_i       = clr;
      enable_i      = en;
      update_i      = upd;
      trace_ready_i = rdy;
      pc_i          = pc;
      instr_i       = instr;
      reg_addr_i    = pc[6:2];
      reg_data_i    = ~pc;
      mem_addr_i    = pc + 32'h0000_1000;
      mem_data_i    = {pc[15:0], pc[31:16]};
      mem_wrt_i     = pc[2];
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      clear_i = 1'b0; enable_i = 1'b0; update_i = 1'b0; trace_ready_i = 1'b0;
   endtask

   initial begin
      rstn_i = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk_head("reset_head", 1'b0, 32'h0, 32'h0, 32'h0);
      chk("reset_level", level_o, 0);
      chk("reset_drop", drop_cnt_o, 0);
      chk("reset_ovf", overflow_o, 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(posedge clk_i);
      #1;

      // ---- table: in-order capture, enable gating, clear with capture ----
      add(0, 1, 1, 1, 32'h00, 1, 0, 32'h00, 1);
      add(0, 1, 1, 1, 32'h04, 1, 1, 32'h04, 1);
      add(0, 1, 1, 1, 32'h08, 1, 2, 32'h08, 1);
      add(0, 1, 0, 1, 32'h0C, 0, 0, 32'h00, 0);
      for (int i = 0; i < 10; i++) add(0, 0, 1, 1, 32'h60 + 4 * i, 0, 0, 32'h0, 0);
      add(0, 1, 1, 0, 32'h20, 1, 3, 32'h20, 1);
      for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 32'h24 + 4 * i, 1, 3, 32'h20, 2 + i);
      add(1, 1, 1, 0, 32'h34, 0, 0, 32'h00, 0);
      add(0, 1, 1, 0, 32'h40, 1, 0, 32'h40, 1);
      add(0, 0, 0, 1, 32'h44, 0, 0, 32'h00, 0);

      foreach (vecs[i]) begin
         step(vecs[i].clr, vecs[i].en, vecs[i].upd, vecs[i].rdy, vecs[i].pc, instr_of(vecs[i].pc));
         chk_head($sformatf("vec%0d_head", i), vecs[i].ev, vecs[i].eseq, vecs[i].epc,
                  instr_of(vecs[i].epc));
         chk($sformatf("vec%0d_level", i), level_o, vecs[i].elvl);
         chk($sformatf("vec%0d_drop", i), drop_cnt_o, 0);
         chk($sformatf("vec%0d_ovf", i), overflow_o, 0);
      end

      // ---- overflow: 20 captures into 16 entries ----
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 32'h1000 + 4 * i, instr_of(32'h1000 + 4 * i));
         chk($sformatf("fill%0d_drop", i), drop_cnt_o, (i >= 16) ? i - 15 : 0);
      end
      chk("fill_level", level_o, 16);
      chk("fill_ovf", overflow_o, 1);
      chk_head("fill_head", 1'b1, 32'h0, 32'h1000, instr_of(32'h1000));

      // ---- full with push and pop in the same cycle ----
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, instr_of(32'h2000));
      chk("pp_level", level_o, 16);
      chk("pp_drop", drop_cnt_o, 4);
      for (int k = 1; k < 16; k++) begin
         chk_head($sformatf("drain%0d_head", k), 1'b1, k, 32'h1000 + 4 * k,
                  instr_of(32'h1000 + 4 * k));
         step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      end
      chk_head("drain_new_head", 1'b1, 32'd20, 32'h2000, instr_of(32'h2000));
      chk("drain_level", level_o, 1);
      chk("drain_drop", drop_cnt_o, 4);
      chk("drain_ovf", overflow_o, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      chk_head("drain_empty_head", 1'b0, 32'h0, 32'h0, 32'h0);
      chk("drain_empty_level", level_o, 0);

      // ---- drop counter saturation (DROP_W=3): 4 + 4 drops clip at 7 ----
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 32'h3000 + 4 * i, instr_of(32'h3000 + 4 * i));
         if (i == 18) chk("sat_reach", drop_cnt_o, 7);
      end
      chk("sat_hold", drop_cnt_o, 7);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("clr_drop", drop_cnt_o, 0);
      chk("clr_ovf", overflow_o, 0);
      chk("clr_level", level_o, 0);

      // ---- ready 0-0-1-0 on a valid head: stable fields, one pop ----
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0050_0093);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h104, instr_of(32'h104));
      chk_head("hold0_head", 1'b1, 32'd0, 32'h100, 32'h0050_0093);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk_head("hold1_head", 1'b1, 32'd0, 32'h100, 32'h0050_0093);
      chk("hold1_level", level_o, 2);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      chk_head("pop1_head", 1'b1, 32'd1, 32'h104, instr_of(32'h104));
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("pop1_level", level_o, 1);

      // ---- asynchronous reset mid-stream at level 7 ----
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 7; i++)
         step(1'b0, 1'b1, 1'b1, 1'b0, 32'h400 + 4 * i, instr_of(32'h400 + 4 * i));
      chk("pre_rst_level", level_o, 7);
      idle_inputs();
      #2;
      rstn_i = 1'b0;
      #1;
      chk_head("arst_head", 1'b0, 32'h0, 32'h0, 32'h0);
      chk("arst_level", level_o, 0);
      chk("arst_drop", drop_cnt_o, 0);
      chk("arst_ovf", overflow_o, 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(posedge clk_i);
      #1;
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h500, instr_of(32'h500));
      chk_head("post_rst_head", 1'b1, 32'd0, 32'h500, instr_of(32'h500));
      chk("post_rst_level", level_o, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
